// File: rtl/yuv_word_unpacker_pkg.sv
// Shared dtype encodings (DTYPE_* macros) and the frame trailer layout.
// The host-side decoder uses the same trailer layout.
`ifndef YUV_DTYPES_DEFINED
`define YUV_DTYPES_DEFINED
`define DTYPE_WIDTH        4
`define DTYPE_FRAME_START  4'h1
`define DTYPE_FRAME_END    4'h2
`define DTYPE_ROW_START    4'h3
`define DTYPE_ROW_END      4'h4
`define DTYPE_HEADER       4'h5
`define DTYPE_PIXEL_Y      4'h8
`define DTYPE_PIXEL_UV     4'h9
`define DTYPE_PIXEL_MASK   4'h8
`endif

package yuv_word_unpacker_pkg;

    localparam int DTYPE_W = `DTYPE_WIDTH;

    localparam logic [DTYPE_W-1:0] DT_FRAME_START = `DTYPE_FRAME_START;
    localparam logic [DTYPE_W-1:0] DT_FRAME_END   = `DTYPE_FRAME_END;
    localparam logic [DTYPE_W-1:0] DT_ROW_START   = `DTYPE_ROW_START;
    localparam logic [DTYPE_W-1:0] DT_ROW_END     = `DTYPE_ROW_END;
    localparam logic [DTYPE_W-1:0] DT_HEADER      = `DTYPE_HEADER;
    localparam logic [DTYPE_W-1:0] DT_PIXEL_Y     = `DTYPE_PIXEL_Y;
    localparam logic [DTYPE_W-1:0] DT_PIXEL_UV    = `DTYPE_PIXEL_UV;
    localparam logic [DTYPE_W-1:0] DT_PIXEL_MASK  = `DTYPE_PIXEL_MASK;

    localparam int TRAILER_FLAG_BIT = 31;
    localparam int TRAILER_COUNT_W  = 24;

    typedef enum logic [1:0] {
        EMPTY,
        LOW,
        HIGH
    } out_state_t;

    function automatic logic [31:0] make_trailer(input logic flag,
                                                 input logic [TRAILER_COUNT_W-1:0] count);
        logic [31:0] word;
        word = '0;
        word[TRAILER_FLAG_BIT] = flag;
        word[TRAILER_COUNT_W-1:0] = count;
        return word;
    endfunction

endpackage

// File: rtl/yuv_word_unpacker_sync_fifo_tagged.sv
// Synchronous FIFO with occupancy output and a look-ahead read of the entry
// behind the head, so the consumer can reload without a bubble.
module sync_fifo_tagged #(
    parameter int WIDTH      = 33,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  resetb,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      head,
    output logic [WIDTH-1:0]      head_next,
    output logic [ADDR_WIDTH:0]   count
);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            if (rd_en)
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + (ADDR_WIDTH+1)'(1);
                2'b01:   count <= count - (ADDR_WIDTH+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= wr_data;
    end

    assign head      = mem[rd_ptr];
    assign head_next = mem[rd_ptr + ADDR_WIDTH'(1)];

endmodule

// File: rtl/yuv_word_unpacker.sv
// Buffers header/pixel words, appends a per-frame trailer and emits 16-bit halfwords.
// Define YUV_WORD_UNPACKER_SWAP_EN to emit the upper halfword first.
module yuv_word_unpacker
    import yuv_word_unpacker_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int CNT_WIDTH  = 24
) (
    input  logic               clk,
    input  logic               resetb,
    input  logic               dvi,
    input  logic [DTYPE_W-1:0] dtypei,
    input  logic [31:0]        datai,
    output logic               dvo,
    input  logic               rdyi,
    output logic [15:0]        datao,
    output logic               frame_endo,
    output logic               overflow,
    output logic [15:0]        drop_count
);

    localparam logic [ADDR_WIDTH:0] DATA_LIMIT = (ADDR_WIDTH+1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] FULL_LEVEL = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE_WORD   = (ADDR_WIDTH+1)'(1);

    logic [CNT_WIDTH-1:0]  frame_count;
    logic [ADDR_WIDTH:0]   occupancy;
    logic [32:0]           head;
    logic [32:0]           head_next;
    logic [32:0]           wr_data;
    logic                  is_data, is_start, is_end;
    logic                  data_ok, trailer_ok, drop, wr_en, rd_en;
    out_state_t            state;
    logic [31:0]           word_q;
    logic                  tag_q;

    assign is_data    = dvi && ((dtypei == DT_HEADER) || |(dtypei & DT_PIXEL_MASK));
    assign is_start   = dvi && (dtypei == DT_FRAME_START);
    assign is_end     = dvi && (dtypei == DT_FRAME_END);
    // The last slot is reserved for the trailer, so data stops one short of full.
    assign data_ok    = is_data && (occupancy < DATA_LIMIT);
    assign trailer_ok = is_end && (occupancy < FULL_LEVEL);
    assign drop       = (is_data && !data_ok) || (is_end && !trailer_ok);
    assign wr_en      = data_ok || trailer_ok;
    assign wr_data    = trailer_ok ? {1'b1, make_trailer(overflow, TRAILER_COUNT_W'(frame_count))}
                                   : {1'b0, datai};
    assign rd_en      = (state == HIGH) && rdyi;

    sync_fifo_tagged #(
        .WIDTH      (33),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .resetb    (resetb),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .head      (head),
        .head_next (head_next),
        .count     (occupancy)
    );

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            frame_count <= '0;
            overflow    <= 1'b0;
            drop_count  <= '0;
        end else begin
            if (data_ok && (frame_count != '1))
                frame_count <= frame_count + CNT_WIDTH'(1);
            if (is_data && !data_ok)
                overflow <= 1'b1;
            if (drop && (drop_count != 16'hFFFF))
                drop_count <= drop_count + 16'd1;
            if (is_start || is_end) begin
                frame_count <= '0;
                overflow    <= 1'b0;
            end
        end
    end

`ifdef YUV_WORD_UNPACKER_SWAP_EN
    function automatic logic [15:0] first_half(input logic [31:0] w);
        return w[31:16];
    endfunction
    function automatic logic [15:0] second_half(input logic [31:0] w);
        return w[15:0];
    endfunction
`else
    function automatic logic [15:0] first_half(input logic [31:0] w);
        return w[15:0];
    endfunction
    function automatic logic [15:0] second_half(input logic [31:0] w);
        return w[31:16];
    endfunction
`endif

    // LOW presents the first-emitted half, HIGH the second (which carries the tag).
    // The head stays in the FIFO until its second half is accepted.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state      <= EMPTY;
            dvo        <= 1'b0;
            datao      <= '0;
            frame_endo <= 1'b0;
            word_q     <= '0;
            tag_q      <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (occupancy != '0) begin
                        word_q     <= head[31:0];
                        tag_q      <= head[32];
                        datao      <= first_half(head[31:0]);
                        dvo        <= 1'b1;
                        frame_endo <= 1'b0;
                        state      <= LOW;
                    end
                end
                LOW: begin
                    if (rdyi) begin
                        datao      <= second_half(word_q);
                        frame_endo <= tag_q;
                        state      <= HIGH;
                    end
                end
                HIGH: begin
                    if (rdyi) begin
                        frame_endo <= 1'b0;
                        if (occupancy > ONE_WORD) begin
                            word_q <= head_next[31:0];
                            tag_q  <= head_next[32];
                            datao  <= first_half(head_next[31:0]);
                            state  <= LOW;
                        end else begin
                            dvo   <= 1'b0;
                            datao <= '0;
                            state <= EMPTY;
                        end
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_yuv_word_unpacker.sv
// Self-checking bench for yuv_word_unpacker: queue-based frame model plus literal checks.
// Honours YUV_WORD_UNPACKER_SWAP_EN for the expected halfword order.
`timescale 1ns/1ps
module tb_yuv_word_unpacker;
    import yuv_word_unpacker_pkg::*;

    localparam int DEPTH = 16;

    logic               clk    = 1'b0;
    logic               resetb = 1'b1;
    logic               dvi    = 1'b0;
    logic [DTYPE_W-1:0] dtypei = '0;
    logic [31:0]        datai  = '0;
    logic               rdyi   = 1'b0;
    logic               dvo;
    logic [15:0]        datao;
    logic               frame_endo;
    logic               overflow;
    logic [15:0]        drop_count;

    int rdy_mode = 0;
    int checks   = 0;
    int fails    = 0;

    typedef struct packed {
        logic [15:0] d;
        logic        fe;
    } half_t;

    half_t       exp_q[$];
    logic [15:0] cap_q[$];
    logic        cap_fe[$];
    int          m_words  = 0;
    int          m_parity = 0;
    int          m_count  = 0;
    logic        m_ovf    = 1'b0;
    int          m_drops  = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data  = '0;

`ifdef YUV_WORD_UNPACKER_SWAP_EN
    logic [15:0] seq4 [10] = '{16'h1122, 16'h3344, 16'h2233, 16'h4455, 16'h3344,
                               16'h5566, 16'h4455, 16'h6677, 16'h0000, 16'h0004};
`else
    logic [15:0] seq4 [10] = '{16'h3344, 16'h1122, 16'h4455, 16'h2233, 16'h5566,
                               16'h3344, 16'h6677, 16'h4455, 16'h0004, 16'h0000};
`endif

    yuv_word_unpacker #(.DEPTH(DEPTH), .ADDR_WIDTH(4), .CNT_WIDTH(24)) dut (
        .clk        (clk),
        .resetb     (resetb),
        .dvi        (dvi),
        .dtypei     (dtypei),
        .datai      (datai),
        .dvo        (dvo),
        .rdyi       (rdyi),
        .datao      (datao),
        .frame_endo (frame_endo),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Downstream ready pattern: always ready, alternating, or stalled.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       rdyi = 1'b1;
            1:       rdyi = ~rdyi;
            default: rdyi = 1'b0;
        endcase
    end

    function automatic void push_word(input logic [31:0] w, input logic tag);
        half_t a, b;
`ifdef YUV_WORD_UNPACKER_SWAP_EN
        a.d = w[31:16];
        b.d = w[15:0];
`else
        a.d = w[15:0];
        b.d = w[31:16];
`endif
        a.fe = 1'b0;
        b.fe = tag;
        exp_q.push_back(a);
        exp_q.push_back(b);
        m_words++;
    endfunction

    function automatic void bump_drop();
        if (m_drops < 65535)
            m_drops++;
    endfunction

    // Frame-level model: buffered words are counted until their last half leaves.
    function automatic void model_accept();
        logic is_data;
        is_data = dvi && ((dtypei == DT_HEADER) || ((dtypei & DT_PIXEL_MASK) != '0));
        if (is_data) begin
            if (m_words < DEPTH - 1) begin
                push_word(datai, 1'b0);
                if (m_count < 'hFFFFFF)
                    m_count++;
            end else begin
                m_ovf = 1'b1;
                bump_drop();
            end
        end else if (dvi && dtypei == DT_FRAME_START) begin
            m_count = 0;
            m_ovf   = 1'b0;
        end else if (dvi && dtypei == DT_FRAME_END) begin
            if (m_words < DEPTH)
                push_word({m_ovf, 7'b0, 24'(m_count)}, 1'b1);
            else
                bump_drop();
            m_count = 0;
            m_ovf   = 1'b0;
        end
    endfunction

    always @(negedge clk) begin
        if (!resetb) begin
            checkOutput("reset_dvo", 32'(dvo), 32'h0);
            checkOutput("reset_frame_endo", 32'(frame_endo), 32'h0);
            checkOutput("reset_overflow", 32'(overflow), 32'h0);
            checkOutput("reset_drop_count", 32'(drop_count), 32'h0);
            exp_q.delete();
            m_words    = 0;
            m_parity   = 0;
            m_count    = 0;
            m_ovf      = 1'b0;
            m_drops    = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checkOutput("hold_dvo", 32'(dvo), 32'h1);
                checkOutput("hold_datao", 32'(datao), 32'(prev_data));
            end
            checkOutput("overflow", 32'(overflow), 32'(m_ovf));
            checkOutput("drop_count", 32'(drop_count), 32'(m_drops));
            if (dvo) begin
                if (exp_q.size() == 0) begin
                    checkOutput("spurious_dvo", 32'(dvo), 32'h0);
                end else begin
                    checkOutput("datao", 32'(datao), 32'(exp_q[0].d));
                    checkOutput("frame_endo", 32'(frame_endo), 32'(exp_q[0].fe));
                end
            end else begin
                checkOutput("idle_frame_endo", 32'(frame_endo), 32'h0);
            end
            prev_stall = dvo && !rdyi;
            prev_data  = datao;
            model_accept();
            if (dvo && rdyi) begin
                cap_q.push_back(datao);
                cap_fe.push_back(frame_endo);
                if (exp_q.size() > 0)
                    void'(exp_q.pop_front());
                if (m_parity == 1)
                    m_words--;
                m_parity = 1 - m_parity;
            end
        end
    end

    task automatic applyStimulus(input logic [DTYPE_W-1:0] dt, input logic [31:0] d);
        @(posedge clk);
        #1;
        dvi    = 1'b1;
        dtypei = dt;
        datai  = d;
    endtask

    task automatic applyIdle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            dvi    = 1'b0;
            dtypei = '0;
            datai  = '0;
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        applyIdle(1);
        while ((exp_q.size() != 0 || dvo) && n < 400) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, "_drained"}, 32'(exp_q.size()), 32'h0);
        applyIdle(2);
    endtask

    task automatic clearCapture();
        cap_q.delete();
        cap_fe.delete();
    endtask

    task automatic checkCap(input string name, input int idx, input logic [15:0] expv, input logic expfe);
        if (idx < cap_q.size()) begin
            checkOutput(name, 32'(cap_q[idx]), 32'(expv));
            checkOutput({name, "_fe"}, 32'(cap_fe[idx]), 32'(expfe));
        end else begin
            checkOutput({name, "_missing"}, 32'(cap_q.size()), 32'(idx + 1));
        end
    endtask

    task automatic checkSeq4(input string name);
        checkOutput({name, "_len"}, 32'(cap_q.size()), 32'd10);
        for (int i = 0; i < 10; i++)
            checkCap($sformatf("%s_half%0d", name, i), i, seq4[i], (i == 9));
    endtask

    task automatic sendFour(input logic with_latency);
        applyStimulus(DT_FRAME_START, 32'h0);
        applyStimulus(DT_PIXEL_Y, 32'h11223344);
        if (with_latency) begin
            applyIdle(1);
            @(negedge clk);
            checkOutput("latency_n1_dvo", 32'(dvo), 32'h0);
            @(negedge clk);
            checkOutput("latency_n2_dvo", 32'(dvo), 32'h1);
        end
        applyStimulus(DT_PIXEL_UV, 32'h22334455);
        applyStimulus(DT_PIXEL_Y, 32'h33445566);
        applyStimulus(DT_PIXEL_UV, 32'h44556677);
        applyStimulus(DT_FRAME_END, 32'h0);
    endtask

    initial begin
        $display("[TB] start");
        #2 resetb = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetb = 1'b1;
        applyIdle(2);

        // Four pixels, always ready.
        rdy_mode = 0;
        clearCapture();
        sendFour(1'b1);
        drain("t1");
        checkSeq4("t1");
        checkOutput("t1_overflow", 32'(overflow), 32'h0);

        // Same stream with alternating ready.
        rdy_mode = 1;
        clearCapture();
        sendFour(1'b0);
        drain("t2");
        checkSeq4("t2");

        // Overfill with a stalled consumer.
        rdy_mode = 2;
        applyIdle(2);
        clearCapture();
        applyStimulus(DT_FRAME_START, 32'h0);
        for (int i = 0; i < 20; i++)
            applyStimulus(DT_PIXEL_Y, 32'h1000_0000 + 32'(i));
        applyStimulus(DT_FRAME_END, 32'h0);
        applyIdle(1);
        @(negedge clk);
        checkOutput("t3_drop_count", 32'(drop_count), 32'd5);
        checkOutput("t3_overflow_cleared", 32'(overflow), 32'h0);
        rdy_mode = 0;
        drain("t3");
        checkOutput("t3_len", 32'(cap_q.size()), 32'd32);
`ifdef YUV_WORD_UNPACKER_SWAP_EN
        checkCap("t3_trailer_a", 30, 16'h8000, 1'b0);
        checkCap("t3_trailer_b", 31, 16'h000F, 1'b1);
`else
        checkCap("t3_trailer_a", 30, 16'h000F, 1'b0);
        checkCap("t3_trailer_b", 31, 16'h8000, 1'b1);
`endif

        // Headers and pixels interleaved with row markers and an unknown dtype.
        clearCapture();
        applyStimulus(DT_FRAME_START, 32'h0);
        applyStimulus(DT_HEADER, 32'hCAFE0001);
        applyStimulus(DT_ROW_START, 32'hDEAD0000);
        applyStimulus(DT_PIXEL_Y, 32'h01020304);
        applyStimulus(DT_ROW_END, 32'hDEAD0001);
        applyStimulus(4'h0, 32'hBAD00000);
        applyStimulus(DT_HEADER, 32'hCAFE0002);
        applyStimulus(DT_PIXEL_UV, 32'h05060708);
        applyStimulus(DT_FRAME_END, 32'h0);
        drain("t4");
        checkOutput("t4_len", 32'(cap_q.size()), 32'd10);
`ifdef YUV_WORD_UNPACKER_SWAP_EN
        checkCap("t4_first", 0, 16'hCAFE, 1'b0);
        checkCap("t4_trailer_a", 8, 16'h0000, 1'b0);
        checkCap("t4_trailer_b", 9, 16'h0004, 1'b1);
`else
        checkCap("t4_first", 0, 16'h0001, 1'b0);
        checkCap("t4_trailer_a", 8, 16'h0004, 1'b0);
        checkCap("t4_trailer_b", 9, 16'h0000, 1'b1);
`endif

        // Reset in the middle of a half-full frame.
        rdy_mode = 2;
        applyStimulus(DT_FRAME_START, 32'h0);
        for (int i = 0; i < 8; i++)
            applyStimulus(DT_PIXEL_Y, 32'h2000_0000 + 32'(i));
        applyIdle(1);
        @(negedge clk);
        checkOutput("t5_pre_dvo", 32'(dvo), 32'h1);
        checkOutput("t5_pre_drop_count", 32'(drop_count), 32'd5);
        @(posedge clk);
        #1 resetb = 1'b0;
        @(negedge clk);
        checkOutput("t5_dvo", 32'(dvo), 32'h0);
        checkOutput("t5_drop_count", 32'(drop_count), 32'h0);
        @(posedge clk);
        #1 resetb = 1'b1;
        rdy_mode = 0;
        applyIdle(5);
        @(negedge clk);
        checkOutput("t5_post_dvo", 32'(dvo), 32'h0);

        // Halfword order of a single word.
        clearCapture();
        applyStimulus(DT_FRAME_START, 32'h0);
        applyStimulus(DT_PIXEL_Y, 32'hAABBCCDD);
        applyStimulus(DT_FRAME_END, 32'h0);
        drain("t6");
        checkOutput("t6_len", 32'(cap_q.size()), 32'd4);
`ifdef YUV_WORD_UNPACKER_SWAP_EN
        checkCap("t6_first", 0, 16'hAABB, 1'b0);
        checkCap("t6_second", 1, 16'hCCDD, 1'b0);
`else
        checkCap("t6_first", 0, 16'hCCDD, 1'b0);
        checkCap("t6_second", 1, 16'hAABB, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
